// File: rtl/aes_inv_key_schedule.sv
// Iterative AES-128 key schedule for decryption: expands the cipher key forward to K10,
// then serves K10 down to K0 one key per handshake from a single 128-bit register.
module aes_inv_key_schedule #(
    parameter int KEY_L     = 128,
    parameter int NO_ROUNDS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [KEY_L-1:0] cipher_key,
    output logic             busy,
    output logic             key_valid,
    input  logic             key_ready,
    output logic [KEY_L-1:0] round_key,
    output logic [3:0]       round_idx,
    output logic             last
);

    typedef enum logic [1:0] {IDLE, EXPAND, SERVE} state_t;

    // Forward AES S-box, byte 0 in the most significant position.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        logic [10:0] base;
        base = 11'd2047 - {x, 3'b000};
        return SBOX_TABLE[base -: 8];
    endfunction

    function automatic logic [31:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h000000};
    endfunction

    state_t           state, state_nxt;
    logic [KEY_L-1:0] key_q, key_nxt;
    logic [3:0]       cnt, cnt_nxt;

    logic [31:0] w_a, w_b, w_c, w_d;
    logic [31:0] inv_d, sub_in, sub_out, rc;
    logic [31:0] fwd_a, fwd_b, fwd_c, fwd_d;
    logic [KEY_L-1:0] fwd_key, inv_key;

    assign {w_a, w_b, w_c, w_d} = key_q;

    // One SubWord serves both directions; the inverse step rotates the already-recovered last word.
    assign inv_d   = w_d ^ w_c;
    assign sub_in  = (state == SERVE) ? {inv_d[23:0], inv_d[31:24]} : {w_d[23:0], w_d[31:24]};
    assign sub_out = {sub_byte(sub_in[31:24]), sub_byte(sub_in[23:16]),
                      sub_byte(sub_in[15:8]),  sub_byte(sub_in[7:0])};
    assign rc      = rcon(cnt);

    assign fwd_a   = w_a ^ sub_out ^ rc;
    assign fwd_b   = w_b ^ fwd_a;
    assign fwd_c   = w_c ^ fwd_b;
    assign fwd_d   = w_d ^ fwd_c;
    assign fwd_key = {fwd_a, fwd_b, fwd_c, fwd_d};
    assign inv_key = {w_a ^ sub_out ^ rc, w_a ^ w_b, w_b ^ w_c, inv_d};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        key_nxt   = key_q;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    key_nxt   = cipher_key;
                    cnt_nxt   = 4'd1;
                    state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                key_nxt = fwd_key;
                if (cnt == 4'(NO_ROUNDS)) begin
                    state_nxt = SERVE;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            SERVE: begin
                if (key_ready) begin
                    if (cnt == 4'd0) begin
                        state_nxt = IDLE;
                    end else begin
                        key_nxt = inv_key;
                        cnt_nxt = cnt - 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so all state updates see pre-edge values.
        if (!reset) begin
            state <= IDLE;
            key_q <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            key_q <= key_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign busy      = (state != IDLE);
    assign key_valid = (state == SERVE);
    assign round_key = key_valid ? key_q : '0;
    assign round_idx = key_valid ? cnt : 4'd0;
    assign last      = key_valid && (cnt == 4'd0);

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed bench for aes_inv_key_schedule using FIPS-197 and all-zero key expansions.
module tb_aes_inv_key_schedule;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_in;
    logic [127:0] cipher_key;
    logic         busy;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         last;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] OTHER_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] ZERO_K10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] ZERO_K1   = 128'h62636363626363636263636362636363;

    logic [127:0] fips_k [0:10];

    always #5 clk = ~clk;

    aes_inv_key_schedule dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .cipher_key (cipher_key),
        .busy       (busy),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .round_key  (round_key),
        .round_idx  (round_idx),
        .last       (last)
    );

    // Presents a key for one edge; returns at the falling edge after the acceptance edge.
    task automatic accept_key(input logic [127:0] k);
        @(negedge clk);
        cipher_key = k;
        valid_in   = 1'b1;
        @(negedge clk);
        valid_in   = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!key_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        reset     = 1'b0;
        valid_in  = 1'b0;
        key_ready = 1'b0;
        cipher_key = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, key_valid, last} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: busy=%b key_valid=%b last=%b, want 0 0 0", busy, key_valid, last);
        end
        checks++;
        if (round_key !== 128'h0 || round_idx !== 4'd0) begin
            errors++;
            $display("FAIL reset_data: key=%h idx=%0d, want 0 and 0", round_key, round_idx);
        end
        reset = 1'b1;
    endtask

    task automatic test_fips_stream;
        int n;
        key_ready = 1'b1;
        accept_key(FIPS_KEY);
        wait_valid(n);
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL fips_latency: got %0d clocks, want 10", n);
        end
        for (int i = 10; i >= 0; i--) begin
            checks++;
            if (key_valid !== 1'b1 || round_idx !== 4'(i) || round_key !== fips_k[i] || last !== (i == 0)) begin
                errors++;
                $display("FAIL fips_k%0d: valid=%b idx=%0d key=%h last=%b, want idx=%0d key=%h",
                         i, key_valid, round_idx, round_key, last, i, fips_k[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL fips_done: busy=%b key_valid=%b, want 0 0", busy, key_valid);
        end
    endtask

    task automatic test_zero_key;
        int n;
        key_ready = 1'b1;
        accept_key(128'h0);
        wait_valid(n);
        checks++;
        if (n != 10 || round_key !== ZERO_K10) begin
            errors++;
            $display("FAIL zero_k10: latency=%0d key=%h, want 10 and %h", n, round_key, ZERO_K10);
        end
        for (int i = 10; i >= 0; i--) begin
            checks++;
            if (round_idx !== 4'(i) || key_valid !== 1'b1) begin
                errors++;
                $display("FAIL zero_idx: valid=%b idx=%0d, want 1 and %0d", key_valid, round_idx, i);
            end
            if (i == 1) begin
                checks++;
                if (round_key !== ZERO_K1) begin
                    errors++;
                    $display("FAIL zero_k1: key=%h, want %h", round_key, ZERO_K1);
                end
            end
            if (i == 0) begin
                checks++;
                if (round_key !== 128'h0 || last !== 1'b1) begin
                    errors++;
                    $display("FAIL zero_k0: key=%h last=%b, want 0 and 1", round_key, last);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure;
        int n;
        int exp_idx;
        int cycles;
        bit done;
        int stalls;
        key_ready = 1'b0;
        accept_key(FIPS_KEY);
        wait_valid(n);
        exp_idx = 10;
        cycles  = 0;
        done    = 1'b0;
        stalls  = 0;
        while (!done && cycles < 300) begin
            key_ready = 1'($urandom_range(0, 1));
            if (!key_ready) stalls++;
            checks++;
            if (key_valid !== 1'b1 || round_idx !== 4'(exp_idx) || round_key !== fips_k[exp_idx]
                || last !== (exp_idx == 0)) begin
                errors++;
                $display("FAIL bp_k%0d: valid=%b idx=%0d key=%h last=%b, want idx=%0d key=%h",
                         exp_idx, key_valid, round_idx, round_key, last, exp_idx, fips_k[exp_idx]);
            end
            if (key_ready) begin
                if (exp_idx == 0) done = 1'b1;
                else exp_idx--;
            end
            @(negedge clk);
            cycles++;
        end
        key_ready = 1'b1;
        checks++;
        if (!done || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_done: finished=%b key_valid=%b stalls=%0d, want 1 and 0", done, key_valid, stalls);
        end
    endtask

    task automatic test_ignore_valid;
        int n;
        key_ready = 1'b1;
        accept_key(FIPS_KEY);
        repeat (3) @(negedge clk);
        cipher_key = OTHER_KEY;
        valid_in   = 1'b1;
        @(negedge clk);
        valid_in   = 1'b0;
        wait_valid(n);
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL ign_latency: got %0d more clocks, want 6", n);
        end
        for (int i = 10; i >= 0; i--) begin
            checks++;
            if (key_valid !== 1'b1 || round_idx !== 4'(i) || round_key !== fips_k[i]) begin
                errors++;
                $display("FAIL ign_k%0d: valid=%b idx=%0d key=%h, want idx=%0d key=%h",
                         i, key_valid, round_idx, round_key, i, fips_k[i]);
            end
            valid_in   = (i == 7);
            cipher_key = OTHER_KEY;
            @(negedge clk);
            valid_in   = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ign_idle: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_mid_reset;
        int n;
        key_ready = 1'b1;
        accept_key(FIPS_KEY);
        wait_valid(n);
        repeat (4) @(negedge clk);
        checks++;
        if (round_idx !== 4'd6 || round_key !== fips_k[6]) begin
            errors++;
            $display("FAIL rst_pre: idx=%0d key=%h, want 6 and %h", round_idx, round_key, fips_k[6]);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if (busy !== 1'b0 || key_valid !== 1'b0 || round_key !== 128'h0 || round_idx !== 4'd0 || last !== 1'b0) begin
            errors++;
            $display("FAIL rst_post: busy=%b valid=%b key=%h idx=%0d last=%b, want all 0",
                     busy, key_valid, round_key, round_idx, last);
        end
        accept_key(FIPS_KEY);
        wait_valid(n);
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL rst_latency: got %0d clocks, want 10", n);
        end
        for (int i = 10; i >= 0; i--) begin
            checks++;
            if (key_valid !== 1'b1 || round_idx !== 4'(i) || round_key !== fips_k[i] || last !== (i == 0)) begin
                errors++;
                $display("FAIL rst_k%0d: valid=%b idx=%0d key=%h last=%b, want idx=%0d key=%h",
                         i, key_valid, round_idx, round_key, last, i, fips_k[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        key_ready = 1'b1;
        accept_key(FIPS_KEY);
        wait_valid(n);
        repeat (10) @(negedge clk);
        checks++;
        if (round_idx !== 4'd0 || last !== 1'b1 || round_key !== FIPS_KEY) begin
            errors++;
            $display("FAIL b2b_k0: idx=%0d last=%b key=%h, want 0 1 %h", round_idx, last, round_key, FIPS_KEY);
        end
        cipher_key = 128'h0;
        valid_in   = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: busy=%b key_valid=%b, want 0 0", busy, key_valid);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b, want 1", busy);
        end
        valid_in = 1'b0;
        wait_valid(n);
        checks++;
        if (n != 10 || round_key !== ZERO_K10 || round_idx !== 4'd10) begin
            errors++;
            $display("FAIL b2b_k10: latency=%0d idx=%0d key=%h, want 10 10 %h", n, round_idx, round_key, ZERO_K10);
        end
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: busy=%b after %0d clocks, want 0", busy, n);
        end
    endtask

    initial begin
        fips_k[0]  = FIPS_KEY;
        fips_k[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_k[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_k[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_k[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_k[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_k[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_k[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_k[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_k[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_k[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        test_reset();
        test_fips_stream();
        test_zero_key();
        test_backpressure();
        test_ignore_valid();
        test_mid_reset();
        test_back_to_back();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

endmodule

// File: doc/aes_inv_key_schedule.md
# aes_inv_key_schedule

Iterative AES-128 key schedule for the decryption datapath. It accepts one cipher key, expands it forward to the last round key, then serves the round keys in reverse order (K10 down to K0) one per handshake. The inverse-cipher round logic pulls these keys in the order it consumes them. Sharing the expansion arithmetic lets one 128-bit register replace an 11-key bus.

## Interface
- KEY_L, 128, cipher/round key width (only 128 supported)
- NO_ROUNDS, 10, number of cipher rounds; keys served = NO_ROUNDS+1

- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- valid_in  in  1  cipher_key valid; accepted only when busy=0
- cipher_key  in  KEY_L  cipher key K0; word0 = [127:96]
- busy  out  1  high from key acceptance until the last key handshake
- key_valid  out  1  round_key/round_idx valid
- key_ready  in  1  consumer accepts the current key
- round_key  out  KEY_L  current round key K[round_idx]
- round_idx  out  4  round number of round_key, 10 down to 0
- last  out  1  high with key_valid when round_idx=0

## Operation
- States: IDLE, EXPAND, SERVE. Reset (reset=0 at an edge) forces IDLE, key register=0, round counter=0, and all outputs to 0.
- IDLE: busy=0, key_valid=0. If valid_in=1: load cipher_key into key register, round counter←1, go to EXPAND.
- EXPAND: each cycle, key register ← fwd(key, RCON[cnt]) and cnt←cnt+1. After the cycle with cnt=10, the register holds K10. Set round_idx←10 and go to SERVE.
- Forward step, with words a,b,c,d = [127:96]..[31:0]:
  - a' = a ^ SubWord(RotWord(d)) ^ rcon
  - b' = b ^ a'
  - c' = c ^ b'
  - d' = d ^ c'
- Inverse step from K_r to K_{r-1}:
  - d' = d ^ c
  - c' = c ^ b
  - b' = b ^ a
  - a' = a ^ SubWord(RotWord(d')) ^ RCON[r]
- RotWord rotates left by one byte. SubWord applies the forward AES S-box to each byte. RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36 in the top byte, lower 24 bits zero.
- S-box: four combinational 256-entry forward S-box lookups, shared by the forward and inverse steps via a mux on the SubWord input word.
- SERVE: key_valid=1; round_key = key register; round_idx = counter; last = (round_idx==0).
  - On key_valid & key_ready with round_idx>0: key register ← inv(key, RCON[round_idx]); round_idx←round_idx−1.
  - On key_valid & key_ready with round_idx=0: go to IDLE.
- valid_in is ignored whenever busy=1; there is no queueing.
- busy=1 in EXPAND and SERVE.

## Timing
- Acceptance edge T0: valid_in=1 in IDLE. EXPAND steps on edges T1..T10. key_valid is high from the cycle after T10. Latency is 10 clocks from the acceptance edge to the first key.
- With key_ready held high, keys K10..K0 transfer on 11 consecutive edges; busy and key_valid drop the cycle after the K0 handshake.
- Backpressure: while key_valid=1 and key_ready=0, round_key, round_idx and last hold stable.
- The earliest next acceptance is the cycle after the K0 handshake, when busy=0. valid_in in the K0 handshake cycle itself is ignored.
- Reset mid-EXPAND or mid-SERVE: at the next edge, go to IDLE with all outputs 0. The partial key is discarded.
- key_ready while key_valid=0 has no effect.

## Test plan
- Stimulus: FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, key_ready=1.
  - Response: key_valid rises 10 clocks after acceptance.
  - Key sequence: K10=d014f9a8c9ee2589e13f0cc8b6630ca6, then K9=ac7766f319fadc2128d12941575c006e, …, K1=a0fafe1788542cb123a339392a6c7605, then K0=cipher key with last=1.
  - 11 consecutive transfers.
- Stimulus: all-zero key.
  - Response: K10=b4ef5bcb3e92e21123e951cf6f8f188e; final K0=0 with last=1.
- Stimulus: same FIPS key, key_ready toggled pseudo-randomly.
  - Response: identical key sequence; outputs stable during every ready=0 cycle; no key skipped or repeated.
- Stimulus: valid_in pulsed with a different key during EXPAND and during SERVE.
  - Response: ignored; the sequence matches the original key.
- Stimulus: reset=0 for one cycle while serving round_idx=6.
  - Response: next cycle busy=0, key_valid=0, round_key=0, round_idx=0.
  - A fresh valid_in afterwards produces the correct full sequence.
- Stimulus: second key presented continuously, starting in the K0 handshake cycle.
  - Response: accepted on the following edge; its K10 appears 10 clocks later.
